// File: rtl/mips_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ram_pkg
//  Purpose  : Shared types and helpers for the MIPS MEM-stage data memory:
//             access-size enum, {Byte, Half} size decode, default depth.
//  Revision : 1.0  initial release
// ============================================================================
package mips_ram_pkg;

  localparam int ADDR_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  // Byte wins over Half; neither selected means a full word.
  function automatic size_e decode_size(input logic byte_sel, input logic half_sel);
    if (byte_sel) return SZ_BYTE;
    if (half_sel) return SZ_HALF;
    return SZ_WORD;
  endfunction

endpackage : mips_ram_pkg
`default_nettype wire

// File: rtl/mips_ram_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ram_if
//  Purpose  : Load/store bus between the CPU MEM stage (master) and the data
//             memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface mips_ram_if;

  logic [31:0] addr;
  logic [31:0] data_in;
  logic        MemWrite;
  logic        Byte;
  logic        Half;
  logic        UnsignedExt_Mem;
  logic [31:0] data_out;

  modport master (
    output addr, data_in, MemWrite, Byte, Half, UnsignedExt_Mem,
    input  data_out
  );

  modport slave (
    input  addr, data_in, MemWrite, Byte, Half, UnsignedExt_Mem,
    output data_out
  );

endinterface : mips_ram_if
`default_nettype wire

// File: rtl/mips_ram_load_ext.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ram_load_ext
//  Purpose  : Selects the byte/half/word out of an aligned 32-bit memory word
//             and sign- or zero-extends it to 32 bits.
//  Options  : RAM_BIG_ENDIAN_EN - big-endian lane selection when defined.
//  Revision : 1.0  initial release
// ============================================================================
module mips_ram_load_ext
  import mips_ram_pkg::*;
(
  input  logic [31:0] word_i,      // lanes already placed in bus byte order
  input  logic [1:0]  off_i,       // address low bits
  input  size_e       size_i,
  input  logic        unsigned_i,  // 1 = zero-extend byte/half
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane out of the aligned word.
  always_comb begin
    byte_sel = '0;
    half_sel = '0;
`ifdef RAM_BIG_ENDIAN_EN
    byte_sel = word_i[{~off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[15:0] : word_i[31:16];
`else
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
`endif
  end

  // Extend the selected lane; words pass through untouched.
  always_comb begin
    data_o = word_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule : mips_ram_load_ext
`default_nettype wire

// File: rtl/mips_ram.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ram
//  Purpose  : Byte-addressed data memory for the MIPS MEM stage. Word, half
//             and byte stores on posedge clk; combinational loads with sign or
//             zero extension; whole array cleared asynchronously by CLR.
//  Options  : RAM_BIG_ENDIAN_EN - big-endian byte order when defined,
//             little-endian otherwise.
//  Revision : 1.0  initial release
// ============================================================================
module mips_ram
  import mips_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
)(
  input  logic        clk,
  input  logic        CLR,
  mips_ram_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem_q [DEPTH];

  logic [ADDR_W-1:0] real_addr;
  logic [ADDR_W-3:0] row;          // aligned word index
  logic [1:0]        off;
  size_e             size;
  logic [3:0]        be;           // byte enables, indexed by offset within the word
  logic [31:0]       lane_data;    // store data replicated across lanes
  logic [ADDR_W-1:0] idx     [4];
  logic [7:0]        wr_byte [4];
  logic [7:0]        rd_byte [4];
  logic [31:0]       word_rd;
  logic [31:0]       load_data;
  logic              unused_addr_hi;

  assign real_addr      = bus.addr[ADDR_W-1:0];
  assign row            = real_addr[ADDR_W-1:2];
  assign off            = real_addr[1:0];
  assign size           = decode_size(bus.Byte, bus.Half);
  assign unused_addr_hi = ^bus.addr[31:ADDR_W];

  // Byte enables and lane replication; alignment falls out of using only
  // the offset bits that matter for each size.
  always_comb begin
    be        = 4'b0000;
    lane_data = bus.data_in;
    case (size)
      SZ_BYTE: begin
        be[off]   = 1'b1;
        lane_data = {4{bus.data_in[7:0]}};
      end
      SZ_HALF: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{bus.data_in[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        lane_data = bus.data_in;
      end
    endcase
  end

  // Per-lane address and byte-order mapping between memory and the bus word.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign idx[i]     = {row, 2'(i)};
    assign rd_byte[i] = mem_q[idx[i]];
`ifdef RAM_BIG_ENDIAN_EN
    assign wr_byte[i]               = lane_data[8*(3-i) +: 8];
    assign word_rd[8*(3-i) +: 8]    = rd_byte[i];
`else
    assign wr_byte[i]               = lane_data[8*i +: 8];
    assign word_rd[8*i +: 8]        = rd_byte[i];
`endif
  end

  // Storage: asynchronous clear of every byte, otherwise enabled lane writes.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[ADDR_W'(k)] <= 8'h00;
      end
    end else if (bus.MemWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx[i]] <= wr_byte[i];
      end
    end
  end

  mips_ram_load_ext u_load_ext (
    .word_i     (word_rd),
    .off_i      (off),
    .size_i     (size),
    .unsigned_i (bus.UnsignedExt_Mem),
    .data_o     (load_data)
  );

  // While CLR is held the array itself reads as zero, so no extra gating.
  assign bus.data_out = load_data;

endmodule : mips_ram
`default_nettype wire

// File: tb/tb_mips_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_ram
//  Purpose  : Self-checking bench for mips_ram (little-endian build).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_ram;

  localparam int AW = 12;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic CLR = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic cmp_en = 1'b0;

  logic [7:0] model_mem [DEPTH];

  mips_ram_if bus ();

  mips_ram #(.ADDR_W(AW)) dut (
    .clk (clk),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic b, input logic h);
    if (b) return 1;
    if (h) return 2;
    return 4;
  endfunction

  function automatic int base_addr(input logic [31:0] a, input int n);
    int ra;
    ra = int'(a[AW-1:0]);
    return ra - (ra % n);
  endfunction

  // Reference load: gather n bytes little-endian, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic b,
                                             input logic h, input logic u);
    int n, base;
    logic [31:0] v;
    n = nbytes(b, h);
    base = base_addr(a, n);
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(model_mem[base + k]) << (8 * k));
    if (n == 1 && !u && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && !u && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) model_mem[k] = 8'h00;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Every negedge with checking enabled: DUT output must match the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_cmp", bus.data_out,
            model_load(bus.addr, bus.Byte, bus.Half, bus.UnsignedExt_Mem));
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic b, input logic h);
    int n, base;
    bus.addr = a; bus.data_in = d; bus.Byte = b; bus.Half = h;
    bus.UnsignedExt_Mem = 1'b0; bus.MemWrite = 1'b1;
    @(posedge clk);
    if (!CLR) begin
      n = nbytes(b, h);
      base = base_addr(a, n);
      for (int k = 0; k < n; k++) model_mem[base + k] = d[8*k +: 8];
    end
    #1;
    bus.MemWrite = 1'b0;
  endtask

  // Directed load: DUT and model both pinned to a hand-computed literal.
  task automatic load_chk(input string name, input logic [31:0] a, input logic b,
                          input logic h, input logic u, input logic [31:0] exp);
    bus.addr = a; bus.Byte = b; bus.Half = h; bus.UnsignedExt_Mem = u;
    bus.MemWrite = 1'b0;
    #2;
    check(name, bus.data_out, exp);
    check({name, "_model"}, model_load(a, b, h, u), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.addr = '0; bus.data_in = '0; bus.MemWrite = 1'b0;
    bus.Byte = 1'b0; bus.Half = 1'b0; bus.UnsignedExt_Mem = 1'b0;
    model_clear();
    #3;
    check("reset_held_out", bus.data_out, 32'h0);
    #17;
    CLR = 1'b0;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;

    load_chk("rst_word0", 32'h0, 0, 0, 0, 32'h0000_0000);
    load_chk("rst_word4", 32'h4, 0, 0, 0, 32'h0000_0000);

    store(32'h0, 32'h1234_5678, 0, 0);
    store(32'h2, 32'h0000_5678, 0, 1);
    load_chk("word0_mix", 32'h0, 0, 0, 0, 32'h5678_5678);
    load_chk("word0_uns_ignored", 32'h0, 0, 0, 1, 32'h5678_5678);
    load_chk("addr_hi_ignored", 32'h0000_1000, 0, 0, 0, 32'h5678_5678);

    store(32'h4, 32'h0000_009a, 1, 0);
    store(32'h6, 32'h0000_00ef, 0, 1);
    load_chk("word4", 32'h4, 0, 0, 0, 32'h00ef_009a);
    load_chk("byte7_s", 32'h7, 1, 0, 0, 32'h0000_0000);
    load_chk("half6_u", 32'h6, 0, 1, 1, 32'h0000_00ef);
    load_chk("byte4_s", 32'h4, 1, 0, 0, 32'hffff_ff9a);

    store(32'h4, 32'h0000_8000, 0, 1);
    load_chk("half4_u", 32'h4, 0, 1, 1, 32'h0000_8000);
    load_chk("half4_s", 32'h4, 0, 1, 0, 32'hffff_8000);
    load_chk("half5_align", 32'h5, 0, 1, 1, 32'h0000_8000);
    load_chk("word6_align", 32'h6, 0, 0, 0, 32'h00ef_8000);

    store(32'h9, 32'h0000_00aa, 1, 1);
    load_chk("byte9_s", 32'h9, 1, 0, 0, 32'hffff_ffaa);
    load_chk("byte9_u", 32'h9, 1, 1, 1, 32'h0000_00aa);
    load_chk("word8", 32'h8, 0, 0, 0, 32'h0000_aa00);

    store(32'hffc, 32'hcafe_f00d, 0, 0);
    load_chk("word_top", 32'hffc, 0, 0, 0, 32'hcafe_f00d);
    load_chk("half_top_s", 32'hffe, 0, 1, 0, 32'hffff_cafe);

    // Async clear mid-store: old data visible, then zero at once, store dropped.
    bus.addr = 32'h0; bus.data_in = 32'hffff_ffff; bus.Byte = 1'b0;
    bus.Half = 1'b0; bus.UnsignedExt_Mem = 1'b0; bus.MemWrite = 1'b1;
    #1;
    check("rdw_old", bus.data_out, 32'h5678_5678);
    #1;
    CLR = 1'b1;
    model_clear();
    #1;
    check("clr_async_zero", bus.data_out, 32'h0);
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    #1;
    CLR = 1'b0;
    load_chk("clr_word0", 32'h0, 0, 0, 0, 32'h0000_0000);
    load_chk("clr_word_top", 32'hffc, 0, 0, 0, 32'h0000_0000);

    store(32'h1, 32'h0000_0011, 1, 0);
    load_chk("post_clr_store", 32'h0, 0, 0, 0, 32'h0000_1100);

    // A few more patterns covered by the per-cycle model compare.
    for (int i = 0; i < 8; i++) begin
      store(32'(16 + 4 * i), 32'h8100_00f1 ^ (32'(i) * 32'h0101_0101), 0, 0);
      store(32'(16 + 4 * i + (i % 4)), 32'(8'h80 + i), 1, 0);
    end
    for (int i = 0; i < 8; i++) begin
      bus.addr = 32'(16 + 4 * i + (i % 4)); bus.Byte = i[0]; bus.Half = i[1];
      bus.UnsignedExt_Mem = i[2];
      @(posedge clk);
      #1;
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mips_ram
`default_nettype wire
